// File: rtl/control_fsm_mc.sv
// Multicycle control FSM for the 16-bit processor datapath.
// Sequences fetch / decode / execute / writeback and drives the strobes for
// the register file, ALU, shifter, PC and dual-port memory. Memory accesses
// (instruction fetch, load, store) use a request/ready handshake. If ready
// does not arrive within TIMEOUT wait cycles, the access is abandoned.
// Illegal opcodes and abandoned accesses raise a one-cycle fault pulse with
// a sticky fault code.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   opCode1, opCode2           instruction opcode fields
//   conditionCode              branch / jump condition select
//   shiftAmtIn / shiftAmtOut   shift amount, passed straight through
//   PSR                        processor status; only PSR[4:0] is used
//   mem_ready, mem_req         memory handshake
//   halt                       hold in FETCH without issuing
//   storeReg .. PCinstruction  single-bit datapath strobes
//   shifterControl, ALUcontrol unit opcodes
//   result                     result mux select
//   fault, fault_code          fault pulse; 01 illegal opcode, 10 timeout
//
// state  | meaning
// -------+----------------------------------------------
// FETCH  | issue the instruction fetch (or idle on halt)
// FWAIT  | wait for instruction memory ready
// DECODE | decode opCode1, load the immediate register
// MEMADR | decode memory / jump sub-op from opCode2
// LRD    | load: wait for data memory ready
// LWR    | load: write the loaded data to the register file
// SWR    | store: write memory, wait for ready
// REX    | register-register ALU execute
// RWR    | register-register writeback
// IEX    | immediate ALU execute
// IWR    | immediate writeback
// SEX    | shift / LUI execute
// SWB    | shift writeback
// BEX    | conditional branch
// JEX    | jump-and-link execute
// JWR    | jump-and-link writeback of the return address
// JCEX   | conditional jump
// FAULT  | one-cycle fault report
module control_fsm_mc #(
  parameter int PSR_W   = 8,
  parameter int TIMEOUT = 15,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opCode1,
  input  logic [3:0]         opCode2,
  input  logic [3:0]         conditionCode,
  input  logic [SHAMT_W-1:0] shiftAmtIn,
  input  logic [PSR_W-1:0]   PSR,
  input  logic               mem_ready,
  input  logic               halt,
  output logic               mem_req,
  output logic               storeReg,
  output logic               zeroExtend,
  output logic               SrcB,
  output logic               JmpEN,
  output logic               BranchEN,
  output logic               JALEN,
  output logic               PCEN,
  output logic               resultEN,
  output logic               immediateRegEN,
  output logic               updateAddress,
  output logic               wren_a,
  output logic               wren_b,
  output logic               nextInstruction,
  output logic               writeData,
  output logic               PSREN,
  output logic               regWriteEN,
  output logic               PCinstruction,
  output logic [3:0]         shifterControl,
  output logic [3:0]         ALUcontrol,
  output logic [1:0]         result,
  output logic [SHAMT_W-1:0] shiftAmtOut,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [4:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_MEMADR, S_LRD, S_LWR, S_SWR, S_REX, S_RWR,
    S_IEX, S_IWR, S_SEX, S_SWB, S_BEX, S_JEX, S_JWR, S_JCEX, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_TC    = 8'(TIMEOUT - 1);
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [1:0] fault_code_q, fault_code_next;
  logic       timeout_hit;
  logic       pass;
  logic [4:0] p;
  logic       unused_psr;

  assign p           = PSR[4:0];
  assign unused_psr  = ^PSR;
  assign shiftAmtOut = shiftAmtIn;
  assign fault_code  = reset ? 2'b00 : fault_code_q;

  // wait_cnt holds the number of wait cycles already spent, so the last
  // permitted wait cycle is the one where it equals TIMEOUT-1.
  assign timeout_hit = (wait_cnt == WAIT_TC);

  always_comb begin
    pass = 1'b0;
    case (conditionCode)
      4'h0: pass = p[4];
      4'h1: pass = !p[4];
      4'h2: pass = p[3];
      4'h3: pass = !p[3];
      4'h4: pass = p[0];
      4'h5: pass = !p[0];
      4'h6: pass = p[1];
      4'h7: pass = !p[1];
      4'h8: pass = p[2];
      4'h9: pass = !p[2];
      4'hA: pass = !p[4] && !p[0];
      4'hB: pass = p[4] || p[0];
      4'hC: pass = !p[1] && !p[4];
      4'hD: pass = p[4] || p[1];
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      fault_code_q <= '0;
    end else begin
      state        <= state_next;
      wait_cnt     <= wait_cnt_next;
      fault_code_q <= fault_code_next;
    end
  end

  // The counter only survives while still waiting; every other path clears it.
  always_comb begin
    state_next      = state;
    wait_cnt_next   = '0;
    fault_code_next = fault_code_q;
    case (state)
      S_FETCH: if (!halt) state_next = S_FWAIT;
      S_FWAIT: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next      = S_FAULT;
          fault_code_next = FC_TIMEOUT;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        case (opCode1)
          4'h0: state_next = S_REX;
          4'h4: state_next = S_MEMADR;
          4'h8, 4'hF: state_next = S_SEX;
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: state_next = S_IEX;
          4'hC: state_next = S_BEX;
          default: begin
            state_next      = S_FAULT;
            fault_code_next = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        case (opCode2)
          4'h0: state_next = S_LRD;
          4'h4: state_next = S_SWR;
          4'h8: state_next = S_JEX;
          4'hA: state_next = S_JCEX;
          default: begin
            state_next      = S_FAULT;
            fault_code_next = FC_ILLEGAL;
          end
        endcase
      end
      S_LRD: begin
        if (mem_ready) begin
          state_next = S_LWR;
        end else if (timeout_hit) begin
          state_next      = S_FAULT;
          fault_code_next = FC_TIMEOUT;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      S_SWR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next      = S_FAULT;
          fault_code_next = FC_TIMEOUT;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      S_REX:   state_next = S_RWR;
      S_IEX:   state_next = S_IWR;
      S_SEX:   state_next = S_SWB;
      S_JEX:   state_next = S_JWR;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req         = 1'b0;
    storeReg        = 1'b0;
    zeroExtend      = 1'b1;
    SrcB            = 1'b1;
    JmpEN           = 1'b0;
    BranchEN        = 1'b0;
    JALEN           = 1'b0;
    PCEN            = 1'b0;
    resultEN        = 1'b0;
    immediateRegEN  = 1'b0;
    updateAddress   = 1'b1;
    wren_a          = 1'b0;
    wren_b          = 1'b0;
    nextInstruction = 1'b0;
    writeData       = 1'b1;
    PSREN           = 1'b0;
    regWriteEN      = 1'b0;
    PCinstruction   = 1'b0;
    shifterControl  = 4'h0;
    ALUcontrol      = 4'h5;
    result          = 2'h1;
    fault           = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          if (!halt) begin
            nextInstruction = 1'b1;
            PCinstruction   = 1'b1;
            PCEN            = 1'b1;
            mem_req         = 1'b1;
          end
        end
        S_FWAIT: begin
          nextInstruction = 1'b1;
          mem_req         = 1'b1;
        end
        S_DECODE: begin
          immediateRegEN = 1'b1;
          SrcB           = 1'b0;
          // Only the logical/unsigned immediate ops keep zero extension
          // when the sign-select bit of opCode2 is set.
          if (opCode2[3])
            zeroExtend = (opCode1 == 4'h1) || (opCode1 == 4'h2) ||
                         (opCode1 == 4'h3) || (opCode1 == 4'hD);
        end
        S_LRD: begin
          updateAddress = 1'b0;
          mem_req       = 1'b1;
        end
        S_LWR: begin
          writeData  = 1'b0;
          regWriteEN = 1'b1;
        end
        S_SWR: begin
          storeReg      = 1'b1;
          updateAddress = 1'b0;
          wren_a        = 1'b1;
          mem_req       = 1'b1;
        end
        S_REX: begin
          ALUcontrol = opCode2;
          PSREN      = 1'b1;
          resultEN   = 1'b1;
        end
        S_RWR: regWriteEN = (opCode2 != 4'hB);
        S_IEX: begin
          ALUcontrol = opCode1;
          SrcB       = 1'b0;
          PSREN      = 1'b1;
          resultEN   = 1'b1;
        end
        S_IWR: regWriteEN = (opCode1 != 4'hB);
        S_SEX: begin
          if (opCode1 == 4'hF) begin
            SrcB           = 1'b0;
            shifterControl = 4'hF;
          end else begin
            SrcB           = (opCode2 == 4'h4);
            shifterControl = opCode2;
          end
          result   = 2'h0;
          resultEN = 1'b1;
        end
        S_SWB: regWriteEN = 1'b1;
        S_BEX: begin
          BranchEN      = pass;
          PCinstruction = 1'b1;
          SrcB          = 1'b0;
          PCEN          = 1'b1;
        end
        S_JEX: begin
          JALEN         = 1'b1;
          PCinstruction = 1'b1;
          result        = 2'h3;
          resultEN      = 1'b1;
          PCEN          = 1'b1;
        end
        S_JWR: regWriteEN = 1'b1;
        S_JCEX: begin
          JmpEN         = pass;
          PCinstruction = 1'b1;
          PCEN          = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm_mc.sv
module tb_control_fsm_mc;
  localparam int PSR_W   = 8;
  localparam int TO      = 15;
  localparam int SHAMT_W = 4;

  logic clk = 1'b0;
  logic reset, mem_ready, halt;
  logic [3:0] opCode1, opCode2, conditionCode;
  logic [SHAMT_W-1:0] shiftAmtIn, shiftAmtOut;
  logic [PSR_W-1:0] PSR;
  logic mem_req, storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN;
  logic resultEN, immediateRegEN, updateAddress, wren_a, wren_b;
  logic nextInstruction, writeData, PSREN, regWriteEN, PCinstruction, fault;
  logic [3:0] shifterControl, ALUcontrol;
  logic [1:0] result, fault_code;

  always #5 clk = ~clk;

  control_fsm_mc #(.PSR_W(PSR_W), .TIMEOUT(TO), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2),
    .conditionCode(conditionCode), .shiftAmtIn(shiftAmtIn), .PSR(PSR),
    .mem_ready(mem_ready), .halt(halt), .mem_req(mem_req), .storeReg(storeReg),
    .zeroExtend(zeroExtend), .SrcB(SrcB), .JmpEN(JmpEN), .BranchEN(BranchEN),
    .JALEN(JALEN), .PCEN(PCEN), .resultEN(resultEN), .immediateRegEN(immediateRegEN),
    .updateAddress(updateAddress), .wren_a(wren_a), .wren_b(wren_b),
    .nextInstruction(nextInstruction), .writeData(writeData), .PSREN(PSREN),
    .regWriteEN(regWriteEN), .PCinstruction(PCinstruction),
    .shifterControl(shifterControl), .ALUcontrol(ALUcontrol), .result(result),
    .shiftAmtOut(shiftAmtOut), .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic mem_req, storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN;
    logic resultEN, immediateRegEN, updateAddress, wren_a, wren_b;
    logic nextInstruction, writeData, PSREN, regWriteEN, PCinstruction, fault;
    logic [3:0] shifterControl;
    logic [3:0] ALUcontrol;
    logic [1:0] result;
    logic [1:0] fault_code;
    logic [SHAMT_W-1:0] shamt;
  } outs_t;

  typedef struct packed {
    logic s_rst;
    logic s_halt;
    logic s_rdy;
  } stim_t;

  outs_t obs;
  assign obs = {mem_req, storeReg, zeroExtend, SrcB, JmpEN, BranchEN, JALEN, PCEN,
                resultEN, immediateRegEN, updateAddress, wren_a, wren_b,
                nextInstruction, writeData, PSREN, regWriteEN, PCinstruction, fault,
                shifterControl, ALUcontrol, result, fault_code, shiftAmtOut};

  outs_t exp_q[$];
  stim_t stim_q[$];
  string tag_q[$];
  logic [1:0] m_fc;
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  function automatic logic rbit();
    return ($urandom() % 2) == 1;
  endfunction

  // Expected outputs when nothing is being driven by the current step.
  function automatic outs_t dflt();
    outs_t o;
    o = '0;
    o.zeroExtend    = 1'b1;
    o.SrcB          = 1'b1;
    o.updateAddress = 1'b1;
    o.writeData     = 1'b1;
    o.ALUcontrol    = 4'h5;
    o.result        = 2'h1;
    o.fault_code    = m_fc;
    o.shamt         = shiftAmtIn;
    return o;
  endfunction

  function automatic void push(outs_t o, logic rst, logic hlt, logic rdy, string tag);
    stim_t s;
    s.s_rst = rst; s.s_halt = hlt; s.s_rdy = rdy;
    exp_q.push_back(o);
    stim_q.push_back(s);
    tag_q.push_back(tag);
  endfunction

  function automatic void push_fault(logic [1:0] code);
    m_fc = code;
    push(dflt() | outs_t'({1'b0, 18'b0, 1'b1, 12'b0, {SHAMT_W{1'b0}}}), 1'b0, rbit(), rbit(), "fault");
  endfunction

  function automatic void push_reset();
    m_fc = 2'b00;
    push(dflt(), 1'b1, rbit(), rbit(), "reset");
  endfunction

  // A memory access is a run of identical wait cycles; ready is low for
  // nlow cycles and then high, unless TO cycles pass first.
  function automatic logic mem_wait(outs_t base, int nlow, string tag);
    for (int k = 0; k < TO; k++) begin
      push(base, 1'b0, rbit(), (k == nlow), tag);
      if (k == nlow) return 1'b0;
    end
    push_fault(2'b10);
    return 1'b1;
  endfunction

  function automatic logic ref_pass(logic [3:0] cc, logic [7:0] psr);
    int flag_bit[5] = '{4, 3, 0, 1, 2};
    if (cc < 4'hA) return psr[flag_bit[cc / 2]] ^ cc[0];
    case (cc)
      4'hA: return !(psr[4] | psr[0]);
      4'hB: return psr[4] | psr[0];
      4'hC: return !(psr[1] | psr[4]);
      4'hD: return psr[4] | psr[1];
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push_fetch();
    outs_t o;
    o = dflt();
    o.nextInstruction = 1'b1; o.PCinstruction = 1'b1; o.PCEN = 1'b1; o.mem_req = 1'b1;
    push(o, 1'b0, 1'b0, rbit(), "fetch");
  endfunction

  // Cycle-by-cycle expectation for one whole instruction.
  function automatic void gen_instr(logic [3:0] op1, logic [3:0] op2, logic [3:0] cc,
                                    logic [7:0] psr, int fw, int mw);
    outs_t o;
    push_fetch();
    o = dflt(); o.nextInstruction = 1'b1; o.mem_req = 1'b1;
    if (mem_wait(o, fw, "fwait")) return;
    o = dflt(); o.immediateRegEN = 1'b1; o.SrcB = 1'b0;
    if (op2[3]) o.zeroExtend = (op1 inside {4'h1, 4'h2, 4'h3, 4'hD});
    push(o, 1'b0, rbit(), rbit(), "decode");
    case (op1)
      4'h0: begin
        o = dflt(); o.ALUcontrol = op2; o.PSREN = 1'b1; o.resultEN = 1'b1;
        push(o, 1'b0, rbit(), rbit(), "rex");
        o = dflt(); o.regWriteEN = (op2 != 4'hB);
        push(o, 1'b0, rbit(), rbit(), "rwr");
      end
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: begin
        o = dflt(); o.ALUcontrol = op1; o.SrcB = 1'b0; o.PSREN = 1'b1; o.resultEN = 1'b1;
        push(o, 1'b0, rbit(), rbit(), "iex");
        o = dflt(); o.regWriteEN = (op1 != 4'hB);
        push(o, 1'b0, rbit(), rbit(), "iwr");
      end
      4'h8, 4'hF: begin
        o = dflt(); o.result = 2'h0; o.resultEN = 1'b1;
        o.SrcB = (op1 == 4'hF) ? 1'b0 : (op2 == 4'h4);
        o.shifterControl = (op1 == 4'hF) ? 4'hF : op2;
        push(o, 1'b0, rbit(), rbit(), "sex");
        o = dflt(); o.regWriteEN = 1'b1;
        push(o, 1'b0, rbit(), rbit(), "swb");
      end
      4'hC: begin
        o = dflt(); o.BranchEN = ref_pass(cc, psr); o.PCinstruction = 1'b1;
        o.SrcB = 1'b0; o.PCEN = 1'b1;
        push(o, 1'b0, rbit(), rbit(), "bex");
      end
      4'h4: begin
        push(dflt(), 1'b0, rbit(), rbit(), "memadr");
        case (op2)
          4'h0: begin
            o = dflt(); o.updateAddress = 1'b0; o.mem_req = 1'b1;
            if (mem_wait(o, mw, "lrd")) return;
            o = dflt(); o.writeData = 1'b0; o.regWriteEN = 1'b1;
            push(o, 1'b0, rbit(), rbit(), "lwr");
          end
          4'h4: begin
            o = dflt(); o.storeReg = 1'b1; o.updateAddress = 1'b0; o.wren_a = 1'b1; o.mem_req = 1'b1;
            void'(mem_wait(o, mw, "swr"));
          end
          4'h8: begin
            o = dflt(); o.JALEN = 1'b1; o.PCinstruction = 1'b1; o.result = 2'h3;
            o.resultEN = 1'b1; o.PCEN = 1'b1;
            push(o, 1'b0, rbit(), rbit(), "jex");
            o = dflt(); o.regWriteEN = 1'b1;
            push(o, 1'b0, rbit(), rbit(), "jwr");
          end
          4'hA: begin
            o = dflt(); o.JmpEN = ref_pass(cc, psr); o.PCinstruction = 1'b1; o.PCEN = 1'b1;
            push(o, 1'b0, rbit(), rbit(), "jcex");
          end
          default: push_fault(2'b01);
        endcase
      end
      default: push_fault(2'b01);
    endcase
  endfunction

  task automatic run_q();
    stim_t s;
    outs_t e;
    string t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      reset = s.s_rst; halt = s.s_halt; mem_ready = s.s_rdy;
      @(negedge clk);
      n_cmp++;
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", t, cyc, obs, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_instr(input logic [3:0] op1, input logic [3:0] op2, input logic [3:0] cc,
                          input logic [7:0] psr, input int fw, input int mw);
    opCode1 = op1; opCode2 = op2; conditionCode = cc; PSR = psr;
    shiftAmtIn = SHAMT_W'($urandom());
    gen_instr(op1, op2, cc, psr, fw, mw);
    run_q();
  endtask

  task automatic do_halt(input int n);
    for (int i = 0; i < n; i++) push(dflt(), 1'b0, 1'b1, rbit(), "halt");
    run_q();
  endtask

  initial begin
    outs_t o;
    int fw, mw;
    logic [3:0] op1, op2;
    reset = 1'b1; halt = 1'b0; mem_ready = 1'b0; opCode1 = '0; opCode2 = '0;
    conditionCode = '0; PSR = '0; shiftAmtIn = '0; m_fc = 2'b00;
    @(posedge clk);
    #1;
    push_reset(); push_reset();
    run_q();

    do_instr(4'h5, 4'h0, 4'h0, 8'h00, 0, 0);   // ADDI
    do_instr(4'h0, 4'hB, 4'h0, 8'h00, 0, 0);   // CMPR
    do_instr(4'h0, 4'h5, 4'h0, 8'h00, 1, 0);   // ADD
    do_instr(4'h4, 4'h0, 4'h0, 8'h00, 0, 3);   // LB, 3 wait cycles
    do_instr(4'h4, 4'h0, 4'h0, 8'h00, TO, 0);  // fetch never ready
    do_instr(4'h6, 4'h0, 4'h0, 8'h00, 0, 0);   // illegal op1
    do_instr(4'h4, 4'h2, 4'h0, 8'h00, 0, 0);   // illegal op2 at MEMADR
    do_instr(4'hC, 4'h0, 4'hA, 8'h00, 0, 0);
    do_instr(4'hC, 4'h0, 4'hA, 8'h10, 0, 0);
    do_instr(4'hC, 4'h0, 4'hE, 8'h1F, 0, 0);
    do_instr(4'hC, 4'h0, 4'hF, 8'h1F, 0, 0);
    do_halt(4);
    do_instr(4'h5, 4'h0, 4'h0, 8'h00, TO - 1, 0); // ready on the last permitted cycle
    do_instr(4'h4, 4'h4, 4'h0, 8'h00, 0, 2);   // store
    do_instr(4'h4, 4'h4, 4'h0, 8'h00, 0, TO);  // store timeout
    do_instr(4'h4, 4'h0, 4'h0, 8'h00, 0, TO);  // load timeout
    do_instr(4'h4, 4'h8, 4'h0, 8'h00, 0, 0);   // JAL
    do_instr(4'h4, 4'hA, 4'h6, 8'h02, 0, 0);   // Jcond
    do_instr(4'h8, 4'h4, 4'h0, 8'h00, 0, 0);   // shift, SrcB from op2
    do_instr(4'hF, 4'h9, 4'h0, 8'h00, 0, 0);   // LUI
    do_instr(4'hB, 4'h8, 4'h0, 8'h00, 0, 0);   // CMPI

    // Reset in the middle of a fetch wait: request drops, no fault.
    opCode1 = 4'h5;
    push_fetch();
    o = dflt(); o.nextInstruction = 1'b1; o.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) push(o, 1'b0, rbit(), 1'b0, "fwait");
    push_reset();
    run_q();
    do_instr(4'h1, 4'h8, 4'h0, 8'h00, 0, 0);

    for (int n = 0; n < 80; n++) begin
      op1 = 4'($urandom());
      op2 = 4'($urandom());
      if (op1 == 4'h4 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: op2 = 4'h0;
          1: op2 = 4'h4;
          2: op2 = 4'h8;
          default: op2 = 4'hA;
        endcase
      end
      fw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) do_halt(int'($urandom_range(1, 3)));
      do_instr(op1, op2, 4'($urandom()), 8'($urandom()), fw, mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
